axis_frame_arb: RTL and testbench

AXIS_FRAME_ARB -- requirements
Module: axis_frame_arb

---
 rtl/axis_frame_arb.sv | 173 +++++++++++++++++
 tb/tb_axis_frame_arb.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arb.sv
// rtl/axis_frame_arb.sv - round-robin AXI-Stream arbiter, S_COUNT inputs to one output
//
// Purpose:
//   Selects one of S_COUNT AXI-Stream inputs and forwards it to a single output.
//   The search starts at (last_grant + 1) mod S_COUNT and wraps around.
//   A one-cycle IDLE arbitration slot always comes before each grant.
//
// Configuration macro:
//   AXIS_FRAME_ARB_LAST_LOCK_EN
//     defined   : the grant is held until a beat with tlast transfers (frame lock)
//     undefined : the grant is released after every transferred beat (per-beat
//                 round-robin); tlast is still forwarded unchanged
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        S_COUNT packed input streams (tdata/tvalid/tready/tlast/tuser)
//   m_axis_*        selected output stream
//   grant_valid     1 while a port owns the output (ACTIVE)
//   grant_index     index of the owning port, stable while grant_valid = 1

module axis_frame_arb #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);

  localparam int IDX_W = $clog2(S_COUNT);
  // Two extra bits hold (last_grant + 1 + offset), which stays below 2*S_COUNT.
  localparam int SUM_W = IDX_W + 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] last_grant_next;
  logic [IDX_W-1:0] grant_sel;
  logic [IDX_W-1:0] grant_sel_next;

  logic [SUM_W-1:0] rr_start;
  logic [SUM_W-1:0] rr_cand;
  logic             rr_found;
  logic [IDX_W-1:0] rr_winner;

  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic [USER_WIDTH-1:0] sel_tuser;
  logic                  xfer;

  // Round-robin search. Candidate j is (last_grant + 1 + j) mod S_COUNT.
  // The modulo is one conditional subtract, because the sum stays below 2*S_COUNT.
  // The candidate is matched against each port by compare instead of variable
  // indexing, so any S_COUNT (power of two or not) is handled the same way.
  assign rr_start = SUM_W'(last_grant) + SUM_W'(1);

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_cand   = '0;
    for (int j = 0; j < S_COUNT; j++) begin
      rr_cand = rr_start + SUM_W'(j);
      if (rr_cand >= SUM_W'(S_COUNT)) begin
        rr_cand = rr_cand - SUM_W'(S_COUNT);
      end
      for (int k = 0; k < S_COUNT; k++) begin
        if (!rr_found && (rr_cand == SUM_W'(k)) && s_axis_tvalid[k]) begin
          rr_found  = 1'b1;
          rr_winner = IDX_W'(k);
        end
      end
    end
  end

  // Mux for the granted port's signals.
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tuser  = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      if (grant_sel == IDX_W'(k)) begin
        sel_tdata  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_tvalid = s_axis_tvalid[k];
        sel_tlast  = s_axis_tlast[k];
        sel_tuser  = s_axis_tuser[k*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Payload always follows the selected port. Only tvalid and tready depend on
  // the state, so no beat can be presented or accepted outside ACTIVE.
  assign m_axis_tdata = sel_tdata;
  assign m_axis_tlast = sel_tlast;
  assign m_axis_tuser = sel_tuser;

  always_comb begin
    state_next      = state;
    grant_sel_next  = grant_sel;
    last_grant_next = last_grant;
    m_axis_tvalid   = 1'b0;
    s_axis_tready   = '0;
    xfer            = 1'b0;

    case (state)
      IDLE: begin
        if (rr_found) begin
          state_next     = ACTIVE;
          grant_sel_next = rr_winner;
        end
      end

      ACTIVE: begin
        m_axis_tvalid = sel_tvalid;
        for (int k = 0; k < S_COUNT; k++) begin
          s_axis_tready[k] = (grant_sel == IDX_W'(k)) && m_axis_tready;
        end
        xfer = sel_tvalid && m_axis_tready;
        // When the granted source drops tvalid, there is no transfer, so the
        // grant is kept. The release depends only on an actual handshake.
`ifdef AXIS_FRAME_ARB_LAST_LOCK_EN
        if (xfer && sel_tlast) begin
          state_next      = IDLE;
          last_grant_next = grant_sel;
        end
`else
        if (xfer) begin
          state_next      = IDLE;
          last_grant_next = grant_sel;
        end
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(S_COUNT - 1);
      grant_sel  <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      grant_sel  <= grant_sel_next;
    end
  end

  assign grant_valid = (state == ACTIVE);
  assign grant_index = grant_sel;

endmodule

// File: tb/tb_axis_frame_arb.sv
// tb/tb_axis_frame_arb.sv - directed self-checking bench for axis_frame_arb

module tb_axis_frame_arb;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int UW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [S*DW-1:0] s_tdata  = '0;
  logic [S-1:0]  s_tvalid = '0;
  logic [S-1:0]  s_tready;
  logic [S-1:0]  s_tlast  = '0;
  logic [S*UW-1:0] s_tuser = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic          grant_valid;
  logic [1:0]    grant_index;

  axis_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-port source queues
  logic [7:0] q_data [S][8];
  logic       q_last [S][8];
  int         q_len  [S];
  int         q_ptr  [S];

  // Per-step patterns: bit n applies to step n (step >= 32: tready 1, no hold)
  logic [31:0] tr_pat;
  logic [31:0] hold_pat;

  // Observed output transfers
  logic [7:0] obs_data [32];
  int         obs_port [32];
  int         obs_cyc  [32];
  logic       obs_last [32];
  int         obs_cnt;
  logic       gv_log   [64];
  int         step_no;

  task automatic clear_model();
    for (int i = 0; i < S; i++) begin
      q_len[i] = 0;
      q_ptr[i] = 0;
    end
    for (int k = 0; k < 32; k++) begin
      obs_data[k] = '0;
      obs_port[k] = -1;
      obs_cyc[k]  = -1;
      obs_last[k] = 1'b0;
    end
    for (int k = 0; k < 64; k++) gv_log[k] = 1'b0;
    obs_cnt  = 0;
    step_no  = 0;
    tr_pat   = '1;
    hold_pat = '0;
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic l);
    q_data[p][q_len[p]] = d;
    q_last[p][q_len[p]] = l;
    q_len[p]++;
  endtask

  task automatic drive_idle();
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive the queue heads just after the rising edge, then sample at
  // the falling edge. A handshake seen there completes on the next rising edge.
  task automatic step();
    logic hold;
    @(posedge clk);
    #1;
    hold     = (step_no < 32) ? hold_pat[step_no] : 1'b0;
    m_tready = (step_no < 32) ? tr_pat[step_no] : 1'b1;
    for (int i = 0; i < S; i++) begin
      if (q_ptr[i] < q_len[i] && !hold) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = q_data[i][q_ptr[i]];
        s_tlast[i]          = q_last[i][q_ptr[i]];
        s_tuser[i]          = q_data[i][q_ptr[i]][0];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i]          = 1'b0;
      end
    end
    @(negedge clk);
    if (step_no < 64) gv_log[step_no] = grant_valid;
    n_checks++;
    if (!grant_valid ? (s_tready != '0 || m_tvalid) :
        ((s_tready & ~(S'(1) << grant_index)) != '0)) begin
      n_fail++;
      $display("FAIL ready_excl step %0d: tready=%b m_tvalid=%b grant_valid=%b grant_index=%0d, required tready only on granted port",
               step_no, s_tready, m_tvalid, grant_valid, grant_index);
    end
    if (m_tvalid) begin
      n_checks++;
      if (m_tuser !== m_tdata[0]) begin
        n_fail++;
        $display("FAIL tuser_fwd step %0d: got %b, required %b", step_no, m_tuser, m_tdata[0]);
      end
    end
    if (m_tvalid && m_tready && obs_cnt < 32) begin
      obs_data[obs_cnt] = m_tdata;
      obs_port[obs_cnt] = int'(grant_index);
      obs_cyc[obs_cnt]  = step_no;
      obs_last[obs_cnt] = m_tlast;
      obs_cnt++;
    end
    for (int i = 0; i < S; i++) begin
      if (s_tready[i] && s_tvalid[i]) q_ptr[i]++;
    end
    step_no++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    clear_model();
    s_tvalid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 4'b0000 || grant_index !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got gv=%b mtv=%b tready=%b gi=%0d, required 0 0 0000 0",
               grant_valid, m_tvalid, s_tready, grant_index);
    end
    s_tvalid = '0;
    rst = 1'b0;
    repeat (6) step();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (gv_log[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle step %0d: grant_valid=%b, required 0", k, gv_log[k]);
      end
    end
    n_checks++;
    if (obs_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_no_xfer: got %0d beats, required 0", obs_cnt);
    end
  endtask

  task automatic test_rr_wrap();
    logic [7:0] ed [8];
    int         ec [8];
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < S; p++) push(p, 8'((r + 1) * 16 + p), 1'b1);
    ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    ec = '{1, 3, 5, 7, 9, 11, 13, 15};
    repeat (20) step();
    n_checks++;
    if (obs_cnt != 8) begin
      n_fail++;
      $display("FAIL rr_count: got %0d beats, required 8", obs_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs_data[k] !== ed[k] || obs_port[k] != (k % 4) || obs_cyc[k] != ec[k] || obs_last[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got data=%h port=%0d cycle=%0d last=%b, required data=%h port=%0d cycle=%0d last=1",
                 k, obs_data[k], obs_port[k], obs_cyc[k], obs_last[k], ed[k], k % 4, ec[k]);
      end
    end
  endtask

  task automatic test_two_frames();
    logic [7:0] ed [4];
    int         ep [4];
    int         ec [4];
    logic [3:0] el;
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
`ifdef AXIS_FRAME_ARB_LAST_LOCK_EN
    ed = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
    ep = '{0, 0, 1, 1};
    ec = '{1, 2, 4, 5};
    el = 4'b1010;
`else
    ed = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    ep = '{0, 1, 0, 1};
    ec = '{1, 3, 5, 7};
    el = 4'b1100;
`endif
    repeat (12) step();
    n_checks++;
    if (obs_cnt != 4) begin
      n_fail++;
      $display("FAIL two_count: got %0d beats, required 4", obs_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_data[k] !== ed[k] || obs_port[k] != ep[k] || obs_cyc[k] != ec[k] || obs_last[k] !== el[k]) begin
        n_fail++;
        $display("FAIL two_beat%0d: got data=%h port=%0d cycle=%0d last=%b, required data=%h port=%0d cycle=%0d last=%b",
                 k, obs_data[k], obs_port[k], obs_cyc[k], obs_last[k], ed[k], ep[k], ec[k], el[k]);
      end
    end
  endtask

  task automatic test_three_beat();
    logic [7:0] ed [6];
    int         ep [6];
    int         ec [6];
    logic [5:0] el;
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
`ifdef AXIS_FRAME_ARB_LAST_LOCK_EN
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
    ep = '{0, 0, 0, 2, 2, 2};
    ec = '{1, 2, 3, 5, 6, 7};
    el = 6'b100100;
`else
    ed = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA2, 8'hC2};
    ep = '{0, 2, 0, 2, 0, 2};
    ec = '{1, 3, 5, 7, 9, 11};
    el = 6'b110000;
`endif
    repeat (16) step();
    n_checks++;
    if (obs_cnt != 6) begin
      n_fail++;
      $display("FAIL three_count: got %0d beats, required 6", obs_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (obs_data[k] !== ed[k] || obs_port[k] != ep[k] || obs_cyc[k] != ec[k] || obs_last[k] !== el[k]) begin
        n_fail++;
        $display("FAIL three_beat%0d: got data=%h port=%0d cycle=%0d last=%b, required data=%h port=%0d cycle=%0d last=%b",
                 k, obs_data[k], obs_port[k], obs_cyc[k], obs_last[k], ed[k], ep[k], ec[k], el[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [4];
    int         ec [4];
    do_reset();
    push(1, 8'hD0, 1'b0); push(1, 8'hD1, 1'b0); push(1, 8'hD2, 1'b0); push(1, 8'hD3, 1'b1);
    tr_pat   = 32'hFFFF_FFFB;
    hold_pat = 32'h0000_0018;
    ed = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
`ifdef AXIS_FRAME_ARB_LAST_LOCK_EN
    ec = '{1, 5, 6, 7};
`else
    ec = '{1, 5, 7, 9};
`endif
    repeat (14) step();
    n_checks++;
    if (obs_cnt != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats, required 4", obs_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_data[k] !== ed[k] || obs_port[k] != 1 || obs_cyc[k] != ec[k]) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got data=%h port=%0d cycle=%0d, required data=%h port=1 cycle=%0d",
                 k, obs_data[k], obs_port[k], obs_cyc[k], ed[k], ec[k]);
      end
    end
    n_checks++;
    if (gv_log[3] !== 1'b1 || gv_log[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold_grant: got gv step3=%b step4=%b, required 1 1", gv_log[3], gv_log[4]);
    end
`ifdef AXIS_FRAME_ARB_LAST_LOCK_EN
    n_checks++;
    if (gv_log[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_lock_stall: got gv step2=%b, required 1", gv_log[2]);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    push(0, 8'h50, 1'b1);
    push(2, 8'h60, 1'b0); push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b1);
    while (obs_cnt < 3 && step_no < 20) step();
    n_checks++;
    if (obs_cnt != 3 || obs_data[2] !== 8'h61 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: got beats=%0d data2=%h gv=%b, required 3 61 1", obs_cnt, obs_data[2], grant_valid);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 4'b0000 || grant_index !== 2'd0) begin
        n_fail++;
        $display("FAIL mid_reset cyc%0d: got gv=%b mtv=%b tready=%b gi=%0d, required 0 0 0000 0",
                 c, grant_valid, m_tvalid, s_tready, grant_index);
      end
    end
    drive_idle();
    clear_model();
    rst = 1'b0;
    push(0, 8'h70, 1'b1);
    push(3, 8'h73, 1'b1);
    repeat (8) step();
    n_checks++;
    if (obs_cnt != 2 || obs_port[0] != 0 || obs_data[0] !== 8'h70 || obs_cyc[0] != 1 ||
        obs_port[1] != 3 || obs_data[1] !== 8'h73 || obs_cyc[1] != 3) begin
      n_fail++;
      $display("FAIL mid_after: got n=%0d p0=%0d d0=%h c0=%0d p1=%0d d1=%h c1=%0d, required 2 0 70 1 3 73 3",
               obs_cnt, obs_port[0], obs_data[0], obs_cyc[0], obs_port[1], obs_data[1], obs_cyc[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_wrap();
    test_two_frames();
    test_three_beat();
    test_backpressure();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
